// File: rtl/csr_unit_irq.sv
// -----------------------------------------------------------------------------
// csr_unit_irq -- machine-mode CSR file with interrupt support.
//
// Holds mstatus (MIE/MPIE), mie, mtvec, mscratch, mepc, mcause, a synchronised
// mip and the 64-bit mcycle/minstret counters. It resolves CSR read/modify/
// write instructions, trap entry and mret, and produces the trap target PC
// and the interrupt request for the core.
//
// Ports:
//   clk_i, rst_i       clock, asynchronous active-low reset
//   opcode_i           funct3 of the CSR instruction (RW/RS/RC and imm forms)
//   addr_i             CSR address
//   rs1_data_i         register operand
//   imm_data_i         zero-extended immediate operand
//   write_enable_i     CSR instruction commits this cycle
//   trap_i, mcause_i, pc_i   trap entry request with its cause and PC
//   mret_i             mret commits this cycle
//   instr_retired_i    one instruction retired this cycle
//   irq_i              asynchronous level-sensitive external interrupts
//   read_data_o        selected CSR value (combinational)
//   illegal_o          illegal CSR access (combinational)
//   trap_pc_o          trap target PC
//   mepc_o             mret target PC
//   irq_req_o          interrupt request to the core
//   irq_cause_o        cause value for the highest-priority pending interrupt
// -----------------------------------------------------------------------------
module csr_unit_irq #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned NUM_IRQ     = 16,
  parameter bit          VECTORED_EN = 1'b1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [2:0]         opcode_i,
  input  logic [11:0]        addr_i,
  input  logic [XLEN-1:0]    rs1_data_i,
  input  logic [XLEN-1:0]    imm_data_i,
  input  logic               write_enable_i,
  input  logic               trap_i,
  input  logic [XLEN-1:0]    mcause_i,
  input  logic [XLEN-1:0]    pc_i,
  input  logic               mret_i,
  input  logic               instr_retired_i,
  input  logic [NUM_IRQ-1:0] irq_i,
  output logic [XLEN-1:0]    read_data_o,
  output logic               illegal_o,
  output logic [XLEN-1:0]    trap_pc_o,
  output logic [XLEN-1:0]    mepc_o,
  output logic               irq_req_o,
  output logic [XLEN-1:0]    irq_cause_o
);

  localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
  localparam logic [11:0] ADDR_MIE       = 12'h304;
  localparam logic [11:0] ADDR_MTVEC     = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
  localparam logic [11:0] ADDR_MEPC      = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
  localparam logic [11:0] ADDR_MIP       = 12'h344;
  localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
  localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
  localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;

  logic                 mstatus_mie_r;
  logic                 mstatus_mpie_r;
  logic [NUM_IRQ-1:0]   mie_r;
  logic [XLEN-1:0]      mtvec_r;
  logic [XLEN-1:0]      mscratch_r;
  logic [XLEN-1:0]      mepc_r;
  logic [XLEN-1:0]      mcause_r;
  logic [NUM_IRQ-1:0]   irq_sync_r;
  logic [NUM_IRQ-1:0]   mip_r;
  logic [63:0]          mcycle_r;
  logic [63:0]          minstret_r;

  logic [XLEN-1:0]      rdata_s;
  logic                 mapped_s;
  logic                 illegal_s;
  logic                 wen_s;
  logic [XLEN-1:0]      operand_s;
  logic [XLEN-1:0]      wdata_s;
  logic [NUM_IRQ-1:0]   irq_pend_s;
  logic [XLEN-2:0]      irq_code_s;
  logic [XLEN-1:0]      tvec_base_s;
  logic [XLEN-1:0]      trap_pc_s;

  // Read mux and address decode; unmapped addresses read as zero.
  always_comb begin
    rdata_s  = {XLEN{1'b0}};
    mapped_s = 1'b1;
    case (addr_i)
      ADDR_MSTATUS: begin
        rdata_s[3] = mstatus_mie_r;
        rdata_s[7] = mstatus_mpie_r;
      end
      ADDR_MIE:       rdata_s[16 +: NUM_IRQ] = mie_r;
      ADDR_MTVEC:     rdata_s = mtvec_r;
      ADDR_MSCRATCH:  rdata_s = mscratch_r;
      ADDR_MEPC:      rdata_s = mepc_r;
      ADDR_MCAUSE:    rdata_s = mcause_r;
      ADDR_MIP:       rdata_s[16 +: NUM_IRQ] = mip_r;
      ADDR_MCYCLE:    rdata_s = XLEN'(mcycle_r[31:0]);
      ADDR_MINSTRET:  rdata_s = XLEN'(minstret_r[31:0]);
      ADDR_MCYCLEH:   rdata_s = XLEN'(mcycle_r[63:32]);
      ADDR_MINSTRETH: rdata_s = XLEN'(minstret_r[63:32]);
      default:        mapped_s = 1'b0;
    endcase
  end

  // Read-modify-write value; funct3[2] selects the immediate operand.
  always_comb begin
    if (opcode_i[2]) begin
      operand_s = imm_data_i;
    end else begin
      operand_s = rs1_data_i;
    end
    case (opcode_i[1:0])
      2'b01:   wdata_s = operand_s;
      2'b10:   wdata_s = rdata_s | operand_s;
      2'b11:   wdata_s = rdata_s & ~operand_s;
      default: wdata_s = rdata_s;
    endcase
  end

  assign illegal_s = write_enable_i & (~mapped_s | (addr_i == ADDR_MIP));
  assign wen_s     = write_enable_i & ~illegal_s;

  // Architectural CSRs; trap beats mret beats a CSR write to the same register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mstatus_mie_r  <= 1'b0;
      mstatus_mpie_r <= 1'b0;
      mie_r          <= {NUM_IRQ{1'b0}};
      mtvec_r        <= {XLEN{1'b0}};
      mscratch_r     <= {XLEN{1'b0}};
      mepc_r         <= {XLEN{1'b0}};
      mcause_r       <= {XLEN{1'b0}};
    end else begin
      if (trap_i) begin
        mstatus_mpie_r <= mstatus_mie_r;
        mstatus_mie_r  <= 1'b0;
      end else if (mret_i) begin
        mstatus_mie_r  <= mstatus_mpie_r;
        mstatus_mpie_r <= 1'b1;
      end else if (wen_s && (addr_i == ADDR_MSTATUS)) begin
        mstatus_mie_r  <= wdata_s[3];
        mstatus_mpie_r <= wdata_s[7];
      end

      if (trap_i) begin
        mepc_r   <= pc_i & ~XLEN'(3);
        mcause_r <= mcause_i;
      end else begin
        if (wen_s && (addr_i == ADDR_MEPC)) begin
          mepc_r <= wdata_s & ~XLEN'(3);
        end
        if (wen_s && (addr_i == ADDR_MCAUSE)) begin
          mcause_r <= wdata_s;
        end
      end

      if (wen_s && (addr_i == ADDR_MIE)) begin
        mie_r <= wdata_s[16 +: NUM_IRQ];
      end
      // mtvec[1] is hard-wired low; mode bit 0 only survives if vectoring exists.
      if (wen_s && (addr_i == ADDR_MTVEC)) begin
        mtvec_r <= {wdata_s[XLEN-1:2], 1'b0, (VECTORED_EN ? wdata_s[0] : 1'b0)};
      end
      if (wen_s && (addr_i == ADDR_MSCRATCH)) begin
        mscratch_r <= wdata_s;
      end
    end
  end

  // 64-bit counters; a write to one half replaces it and skips that cycle's increment.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mcycle_r   <= 64'd0;
      minstret_r <= 64'd0;
    end else begin
      if (wen_s && (addr_i == ADDR_MCYCLE)) begin
        mcycle_r[31:0] <= 32'(wdata_s);
      end else if (wen_s && (addr_i == ADDR_MCYCLEH)) begin
        mcycle_r[63:32] <= 32'(wdata_s);
      end else begin
        mcycle_r <= mcycle_r + 64'd1;
      end

      if (wen_s && (addr_i == ADDR_MINSTRET)) begin
        minstret_r[31:0] <= 32'(wdata_s);
      end else if (wen_s && (addr_i == ADDR_MINSTRETH)) begin
        minstret_r[63:32] <= 32'(wdata_s);
      end else if (instr_retired_i) begin
        minstret_r <= minstret_r + 64'd1;
      end
    end
  end

  // Two-flop synchroniser for the asynchronous interrupt lines; second stage is mip.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      irq_sync_r <= {NUM_IRQ{1'b0}};
      mip_r      <= {NUM_IRQ{1'b0}};
    end else begin
      irq_sync_r <= irq_i;
      mip_r      <= irq_sync_r;
    end
  end

  assign irq_pend_s = mip_r & mie_r;

  // Lowest-numbered pending line wins; scanning downward leaves the lowest set index.
  always_comb begin
    irq_code_s = (XLEN-1)'(16);
    for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
      if (irq_pend_s[i]) begin
        irq_code_s = (XLEN-1)'(16 + i);
      end else begin
        irq_code_s = irq_code_s;
      end
    end
  end

  // Trap target: vectored mode offsets the base by 4*cause only for interrupts.
  always_comb begin
    tvec_base_s = {mtvec_r[XLEN-1:2], 2'b00};
    if ((mtvec_r[1:0] == 2'b01) && mcause_r[XLEN-1]) begin
      trap_pc_s = tvec_base_s + {mcause_r[XLEN-3:0], 2'b00};
    end else begin
      trap_pc_s = tvec_base_s;
    end
  end

  assign read_data_o = rdata_s;
  assign illegal_o   = illegal_s;
  assign trap_pc_o   = trap_pc_s;
  assign mepc_o      = mepc_r;
  assign irq_req_o   = mstatus_mie_r & (|irq_pend_s);
  assign irq_cause_o = {1'b1, irq_code_s};

endmodule

// File: tb/tb_csr_unit_irq.sv
module tb_csr_unit_irq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  opcode = 3'd0;
  logic [11:0] addr = 12'd0;
  logic [31:0] rs1 = 32'd0;
  logic [31:0] imm = 32'd0;
  logic        we = 1'b0;
  logic        trap = 1'b0;
  logic [31:0] mcause_in = 32'd0;
  logic [31:0] pc = 32'd0;
  logic        mret = 1'b0;
  logic        iret = 1'b0;
  logic [15:0] irq = 16'd0;
  logic [31:0] read_data;
  logic        illegal;
  logic [31:0] trap_pc;
  logic [31:0] mepc_out;
  logic        irq_req;
  logic [31:0] irq_cause;

  int n_chk = 0;
  int n_err = 0;

  csr_unit_irq #(.XLEN(32), .NUM_IRQ(16), .VECTORED_EN(1'b1)) dut (
    .clk_i(clk), .rst_i(rst_n), .opcode_i(opcode), .addr_i(addr),
    .rs1_data_i(rs1), .imm_data_i(imm), .write_enable_i(we),
    .trap_i(trap), .mcause_i(mcause_in), .pc_i(pc), .mret_i(mret),
    .instr_retired_i(iret), .irq_i(irq), .read_data_o(read_data),
    .illegal_o(illegal), .trap_pc_o(trap_pc), .mepc_o(mepc_out),
    .irq_req_o(irq_req), .irq_cause_o(irq_cause)
  );

  always #5 clk = ~clk;

  // ---------------- reference model (architectural view) ----------------
  logic        m_mie_b, m_mpie;
  logic [31:0] m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause;
  logic [15:0] m_seen [0:1];   // irq samples: [0] one edge ago, [1] two edges ago
  logic [63:0] m_cycle, m_instret;

  function automatic logic m_mapped(input logic [11:0] a);
    return a inside {12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                     12'h344, 12'hB00, 12'hB02, 12'hB80, 12'hB82};
  endfunction

  function automatic logic [31:0] m_read(input logic [11:0] a);
    case (a)
      12'h300: return {24'd0, m_mpie, 3'd0, m_mie_b, 3'd0};
      12'h304: return m_mie;
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h344: return {m_seen[1], 16'd0};
      12'hB00: return m_cycle[31:0];
      12'hB80: return m_cycle[63:32];
      12'hB02: return m_instret[31:0];
      12'hB82: return m_instret[63:32];
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic m_illegal();
    return we && (!m_mapped(addr) || addr == 12'h344);
  endfunction

  function automatic logic [31:0] m_wval();
    logic [31:0] op;
    op = opcode[2] ? imm : rs1;
    case (opcode[1:0])
      2'b01:   return op;
      2'b10:   return m_read(addr) | op;
      2'b11:   return m_read(addr) & ~op;
      default: return m_read(addr);
    endcase
  endfunction

  function automatic logic [31:0] m_trap_pc();
    logic [31:0] base;
    base = m_mtvec & ~32'd3;
    if (m_mtvec[1:0] == 2'b01 && m_mcause[31]) return base + 32'd4 * {1'b0, m_mcause[30:0]};
    return base;
  endfunction

  function automatic logic [31:0] m_pending();
    return {m_seen[1], 16'd0} & m_mie;
  endfunction

  function automatic logic [31:0] m_cause();
    logic [31:0] p;
    p = m_pending();
    for (int b = 16; b < 32; b++) if (p[b]) return 32'h8000_0000 + b;
    return 32'h8000_0010;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mie_b <= 1'b0; m_mpie <= 1'b0; m_mie <= 32'd0; m_mtvec <= 32'd0;
      m_mscratch <= 32'd0; m_mepc <= 32'd0; m_mcause <= 32'd0;
      m_seen[0] <= 16'd0; m_seen[1] <= 16'd0;
      m_cycle <= 64'd0; m_instret <= 64'd0;
    end else begin
      m_seen[0] <= irq;
      m_seen[1] <= m_seen[0];
      m_cycle   <= m_cycle + 64'd1;
      if (iret) m_instret <= m_instret + 64'd1;
      if (we && !m_illegal()) begin
        case (addr)
          12'h300: if (!trap && !mret) begin m_mie_b <= m_wval()[3]; m_mpie <= m_wval()[7]; end
          12'h304: m_mie <= m_wval() & 32'hFFFF_0000;
          12'h305: m_mtvec <= m_wval() & ~32'd2;
          12'h340: m_mscratch <= m_wval();
          12'h341: if (!trap) m_mepc <= m_wval() & ~32'd3;
          12'h342: if (!trap) m_mcause <= m_wval();
          12'hB00: m_cycle <= {m_cycle[63:32], m_wval()};
          12'hB80: m_cycle <= {m_wval(), m_cycle[31:0]};
          12'hB02: m_instret <= {m_instret[63:32], m_wval()};
          12'hB82: m_instret <= {m_wval(), m_instret[31:0]};
          default: ;
        endcase
      end
      if (trap) begin
        m_mepc <= pc & ~32'd3; m_mcause <= mcause_in; m_mpie <= m_mie_b; m_mie_b <= 1'b0;
      end else if (mret) begin
        m_mie_b <= m_mpie; m_mpie <= 1'b1;
      end
    end
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_loop();
    forever begin
      @(negedge clk);
      chk("cmp read_data", read_data, m_read(addr));
      chk("cmp illegal", {31'd0, illegal}, {31'd0, m_illegal()});
      chk("cmp trap_pc", trap_pc, m_trap_pc());
      chk("cmp mepc", mepc_out, m_mepc);
      chk("cmp irq_req", {31'd0, irq_req}, {31'd0, m_mie_b & (|m_pending())});
      chk("cmp irq_cause", irq_cause, m_cause());
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    we = 1'b0; trap = 1'b0; mret = 1'b0; iret = 1'b0;
  endtask

  task automatic csr(input logic [2:0] op, input logic [11:0] a, input logic [31:0] v);
    step();
    opcode = op; addr = a; rs1 = v; imm = v; we = 1'b1;
  endtask

  task automatic rd(input logic [11:0] a, input logic [31:0] exp, input string name);
    addr = a;
    #1;
    chk(name, read_data, exp);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    fork compare_loop(); join_none

    #2;
    rd(12'h300, 32'd0, "reset mstatus");
    rd(12'h305, 32'd0, "reset mtvec");
    chk("reset irq_req", {31'd0, irq_req}, 32'd0);
    chk("reset irq_cause", irq_cause, 32'h8000_0010);
    #8 rst_n = 1'b1;

    csr(3'b001, 12'h340, 32'hDEAD_BEEF);
    csr(3'b010, 12'h340, 32'h0000_0010);
    step(); rd(12'h340, 32'hDEAD_BEFF, "mscratch RS");
    csr(3'b111, 12'h340, 32'h0000_000F);   // RCI form
    step(); rd(12'h340, 32'hDEAD_BEF0, "mscratch RC");

    // interrupt path
    csr(3'b001, 12'h300, 32'h0000_0008);
    csr(3'b001, 12'h304, 32'h0004_0000);
    step(); irq = 16'h0004;
    #1 chk("irq latency 0", {31'd0, irq_req}, 32'd0);
    step(); chk("irq latency 1", {31'd0, irq_req}, 32'd0);
    step(); chk("irq latency 2", {31'd0, irq_req}, 32'd1);
    chk("irq cause", irq_cause, 32'h8000_0012);
    csr(3'b001, 12'h344, 32'd0);
    #1 chk("mip write illegal", {31'd0, illegal}, 32'd1);
    step(); rd(12'h344, 32'h0004_0000, "mip unchanged");
    csr(3'b001, 12'h123, 32'h5);
    #1 chk("unmapped illegal", {31'd0, illegal}, 32'd1);
    chk("unmapped read", read_data, 32'd0);
    step(); irq = 16'h0000;

    // vectored trap and mret
    csr(3'b001, 12'h305, 32'h0000_1001);
    step(); trap = 1'b1; mcause_in = 32'h8000_0013; pc = 32'h0000_2006;
    step();
    chk("vectored trap_pc", trap_pc, 32'h0000_104C);
    chk("trap mepc", mepc_out, 32'h0000_2004);
    rd(12'h300, 32'h0000_0080, "trap mstatus");
    mret = 1'b1;
    step(); rd(12'h300, 32'h0000_0088, "mret mstatus");

    // priority: trap over mepc write, mret over mstatus write
    step(); trap = 1'b1; pc = 32'h0000_3008; mcause_in = 32'h0000_0005;
    we = 1'b1; opcode = 3'b001; addr = 12'h341; rs1 = 32'h0000_1234;
    step();
    chk("trap beats write", mepc_out, 32'h0000_3008);
    chk("exception trap_pc", trap_pc, 32'h0000_1000);
    csr(3'b001, 12'h300, 32'd0);
    step(); mret = 1'b1; we = 1'b1; opcode = 3'b001; addr = 12'h300; rs1 = 32'd0;
    step(); rd(12'h300, 32'h0000_0080, "mret beats write");

    // counters
    csr(3'b001, 12'hB00, 32'hFFFF_FFFE);
    csr(3'b001, 12'hB80, 32'd0);
    step(); rd(12'hB00, 32'hFFFF_FFFE, "mcycle written");
    step();
    step(); rd(12'hB00, 32'd0, "mcycle wrap lo");
    rd(12'hB80, 32'd1, "mcycle wrap hi");
    for (int k = 0; k < 5; k++) begin
      step(); iret = 1'b1;
    end
    step(); rd(12'hB02, 32'd5, "minstret");
    rd(12'hB82, 32'd0, "minstreth");

    // asynchronous reset between edges during a trap
    step(); trap = 1'b1; pc = 32'h0000_4000; mcause_in = 32'h8000_0011; addr = 12'h341;
    #2 rst_n = 1'b0;
    #1;
    chk("async rst read", read_data, 32'd0);
    chk("async rst trap_pc", trap_pc, 32'd0);
    chk("async rst mepc", mepc_out, 32'd0);
    chk("async rst irq_req", {31'd0, irq_req}, 32'd0);
    chk("async rst irq_cause", irq_cause, 32'h8000_0010);
    trap = 1'b0;
    @(posedge clk); #3 rst_n = 1'b1;
    step(); step();
    rd(12'h300, 32'd0, "post reset mstatus");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/csr_unit_irq.md
Name: csr_unit_irq

Overview:
Next-generation machine-mode CSR block for the core, parametrised in XLEN and external interrupt count. It extends the basic mie/mtvec/mscratch/mepc/mcause file with mstatus trap/mret stacking, synchronised interrupt pending (mip), vectored trap targets, 64-bit cycle/instret counters and illegal-access detection. It sits beside the decoder/trap logic and feeds the PC mux.

Parameters:
XLEN, 32, CSR data width; counters are always 64 bits, split into low/high halves.
NUM_IRQ, 16, external interrupt lines mapped to mip/mie bits [16 +: NUM_IRQ]; legal range 1..XLEN-16.
VECTORED_EN, 1, 1 = mtvec mode 01 (vectored) supported; 0 = mode forced to 00.

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-low
opcode_i  in  3  CSR op (funct3): RW=001 RS=010 RC=011 RWI=101 RSI=110 RCI=111
addr_i  in  12  CSR address
rs1_data_i  in  XLEN  register operand
imm_data_i  in  XLEN  zero-extended uimm operand
write_enable_i  in  1  CSR instruction commits this cycle
trap_i  in  1  take a trap this cycle
mcause_i  in  XLEN  cause for the trap
pc_i  in  XLEN  PC of the trapping instruction
mret_i  in  1  mret commits this cycle
instr_retired_i  in  1  one instruction retired
irq_i  in  NUM_IRQ  asynchronous level interrupt lines
read_data_o  out  XLEN  selected CSR value (combinational)
illegal_o  out  1  illegal CSR access (combinational)
trap_pc_o  out  XLEN  trap target PC
mepc_o  out  XLEN  mret target
irq_req_o  out  1  interrupt request to core
irq_cause_o  out  XLEN  cause value for the pending interrupt

Behaviour:
- Map: mstatus 0x300 (MIE bit3, MPIE bit7, others read 0), mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mip 0x344 (read-only), mcycle 0xB00, minstret 0xB02, mcycleh 0xB80, minstreth 0xB82.
- Reset (rst_i low, async): all CSRs and counters 0, irq sync flops 0. Resulting outputs: read_data_o 0 for any address, trap_pc_o 0, mepc_o 0, irq_req_o 0, irq_cause_o 0x80000010.
- Write value: RW/RWI = operand; RS/RSI = old | operand; RC/RCI = old & ~operand. Written on the clock edge when write_enable_i=1 and illegal_o=0.
- illegal_o = write_enable_i & (unmapped address, or write to mip). Unmapped reads return 0. No state changes when illegal.
- WARL: mepc[1:0] forced 00; mtvec[1] forced 0 (mtvec[0] forced 0 when VECTORED_EN=0); mie bits outside [16 +: NUM_IRQ] read 0.
- Trap (trap_i): mepc<=pc_i & ~3, mcause<=mcause_i, MPIE<=MIE, MIE<=0.
- mret (mret_i): MIE<=MPIE, MPIE<=1.
- Priority in one cycle: trap > mret > CSR write. A CSR write to the same register is dropped. Counter writes still apply.
- trap_pc_o: when mtvec mode=01 and mcause[XLEN-1]=1, output {base} + 4*mcause[XLEN-2:0]; otherwise {base}. base = mtvec[XLEN-1:2]<<2. Purely combinational from registers.
- mip: irq_i passes through a 2-flop synchroniser into mip[16 +: NUM_IRQ]. Latency: an irq_i edge appears in mip after 2 clocks, and irq_req_o follows the same cycle as mip.
- irq_req_o = MIE & |(mip & mie). irq_cause_o = {1'b1, 16 + lowest set index of (mip & mie)}. When none is pending, output {1,16}.
- mcycle (64-bit) increments every cycle. minstret increments when instr_retired_i=1. Both wrap at 2^64-1 -> 0.
- A write to either half replaces that half. That cycle suppresses the increment for that counter, and the other half holds.

Test Plan:
- Reset -> read 0x300/0x305 = 0, irq_req_o=0. Write mscratch RW 0xDEADBEEF, then RS 0x10, then RC 0x0F -> reads 0xDEADBEFF, then 0xDEADBEF0.
- Set MIE=1 and mie bit 18. Pulse irq_i[2] high -> irq_req_o=1 exactly 2 clocks later, irq_cause_o=0x80000012. Write 0x344 -> illegal_o=1 and mip unchanged.
- Write mtvec 0x00001001, trap_i with mcause 0x80000013 and pc 0x2006 -> trap_pc_o=0x104C, mepc=0x2004, MIE=0, MPIE=1. Then mret -> MIE=1, MPIE=1.
- Assert trap_i and a CSR write to mepc in the same cycle -> mepc=pc_i & ~3 and the write is dropped. Assert mret and a write of mstatus=0 together -> MIE=MPIE.
- Write mcycle=0xFFFFFFFE, mcycleh=0 -> after 2 clocks low half wraps to 0 and high half becomes 1. Hold instr_retired_i high for 5 clocks -> minstret=5.
- Drop rst_i asynchronously mid-trap, between clock edges -> all outputs return to their reset values immediately, with no clock edge needed.
